// File: rtl/bus_arb_pkg.sv
// Shared constants and types for the system-bus master arbiter and its picker.
// Master index constants, bus state encoding and the default hold-time limit.
package bus_arb_pkg;

  localparam logic YES = 1'b1;
  localparam logic NO  = 1'b0;

  localparam int WORD_ADDR_W = 32;
  typedef logic [WORD_ADDR_W-1:0] word_addr_t;

  localparam logic [1:0] MASTER_0 = 2'd0;
  localparam logic [1:0] MASTER_1 = 2'd1;
  localparam logic [1:0] MASTER_2 = 2'd2;
  localparam logic [1:0] MASTER_3 = 2'd3;

  typedef enum logic {
    BUS_ARB_IDLE  = 1'b0,
    BUS_ARB_OWNED = 1'b1
  } arb_state_e;

  localparam int MAX_HOLD_DEFAULT = 16;

  function automatic logic [3:0] master_onehot(input logic [1:0] idx);
    logic [3:0] oh;
    case (idx)
      MASTER_0: oh = 4'b0001;
      MASTER_1: oh = 4'b0010;
      MASTER_2: oh = 4'b0100;
      MASTER_3: oh = 4'b1000;
      default:  oh = 4'b0000;
    endcase
    return oh;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first requester after `last`, wrapping,
// optionally skipping one excluded index.
module rr_pick
  import bus_arb_pkg::*;
(
  input  logic [3:0] req,
  input  logic [1:0] last,
  input  logic       excl_en,
  input  logic [1:0] excl_idx,
  output logic       valid,
  output logic [1:0] idx
);

  logic [3:0] masked;
  logic [1:0] cand;

  // NOTE: every variable gets a default before any branch; otherwise an
  // unassigned path infers a latch.
  always_comb begin
    masked = req;
    if (excl_en) masked[excl_idx] = 1'b0;
    valid = NO;
    idx   = last;
    cand  = last;
    // Walk from farthest to nearest so the nearest requester wins.
    for (int k = 4; k >= 1; k--) begin
      cand = last + 2'(k);
      if (masked[cand]) begin
        valid = YES;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/bus_arb.sv
// Round-robin arbiter for four bus masters with a hold-time limit; muxes the
// owner's address and control onto the shared bus feeding the slave decoder.
module bus_arb
  import bus_arb_pkg::*;
#(
  parameter int NUM_M    = 4,
  parameter int MAX_HOLD = MAX_HOLD_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_M-1:0]      m_req,
  input  logic [NUM_M*32-1:0]   m_addr,
  input  logic [NUM_M-1:0]      m_as,
  input  logic [NUM_M-1:0]      m_rw,
  input  logic [NUM_M*32-1:0]   m_wr_data,
  output logic [NUM_M-1:0]      m_grnt,
  output logic                  m_rdy,
  output logic [31:0]           s_addr,
  output logic                  s_as,
  output logic                  s_rw,
  output logic [31:0]           s_wr_data,
  input  logic                  s_rdy
);

  localparam int HOLD_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) + 1 : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = (MAX_HOLD > 0) ? HOLD_W'(MAX_HOLD - 1) : '0;
  localparam logic LIMIT_EN = (MAX_HOLD != 0);

  arb_state_e        state_q, state_d;
  logic [1:0]        owner_q, owner_d;
  logic [1:0]        last_q, last_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [3:0]        grnt_q, grnt_d;

  logic       rel_valid, to_valid;
  logic [1:0] rel_idx, to_idx;
  logic       other_req, timeout;

  // Release/idle path: owner's request is already low, so no exclusion needed.
  rr_pick u_pick_rel (
    .req      (m_req),
    .last     (last_q),
    .excl_en  (NO),
    .excl_idx (owner_q),
    .valid    (rel_valid),
    .idx      (rel_idx)
  );

  rr_pick u_pick_to (
    .req      (m_req),
    .last     (last_q),
    .excl_en  (YES),
    .excl_idx (owner_q),
    .valid    (to_valid),
    .idx      (to_idx)
  );

  assign other_req = |(m_req & ~master_onehot(owner_q));
  // Preemption waits for the owner's strobe to drop so a transfer is never cut.
  assign timeout   = LIMIT_EN && (hold_q == HOLD_LAST) && other_req && !m_as[owner_q];

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    hold_d  = hold_q;
    grnt_d  = grnt_q;
    case (state_q)
      BUS_ARB_IDLE: begin
        if (rel_valid) begin
          state_d = BUS_ARB_OWNED;
          owner_d = rel_idx;
          last_d  = rel_idx;
          hold_d  = '0;
          grnt_d  = master_onehot(rel_idx);
        end
      end
      BUS_ARB_OWNED: begin
        if (!m_req[owner_q]) begin
          if (rel_valid) begin
            owner_d = rel_idx;
            last_d  = rel_idx;
            hold_d  = '0;
            grnt_d  = master_onehot(rel_idx);
          end else begin
            state_d = BUS_ARB_IDLE;
            hold_d  = '0;
            grnt_d  = '0;
          end
        end else if (timeout && to_valid) begin
          owner_d = to_idx;
          last_d  = to_idx;
          hold_d  = '0;
          grnt_d  = master_onehot(to_idx);
        end else if (LIMIT_EN && hold_q != HOLD_LAST) begin
          hold_d = hold_q + 1'b1;
        end
      end
      default: begin
        state_d = BUS_ARB_IDLE;
        grnt_d  = '0;
      end
    endcase
  end

  // NOTE: sequential state is written with <= only, so every register samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= BUS_ARB_IDLE;
      owner_q <= MASTER_0;
      last_q  <= MASTER_3;
      hold_q  <= '0;
      grnt_q  <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      hold_q  <= hold_d;
      grnt_q  <= grnt_d;
    end
  end

  assign m_grnt = grnt_q;
  assign m_rdy  = s_rdy;

  always_comb begin
    s_addr    = '0;
    s_as      = NO;
    s_rw      = 1'b0;
    s_wr_data = '0;
    if (|grnt_q) begin
      s_addr    = m_addr[{owner_q, 5'b0} +: 32];
      s_as      = m_as[owner_q];
      s_rw      = m_rw[owner_q];
      s_wr_data = m_wr_data[{owner_q, 5'b0} +: 32];
    end
  end

endmodule

// File: tb/tb_bus_arb.sv
// Self-checking bench for bus_arb: directed scenarios plus random traffic,
// compared every cycle against a behavioural arbitration model.
module tb_bus_arb;

  localparam int MH = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   m_req, m_as, m_rw;
  logic [127:0] m_addr, m_wr_data;
  logic [3:0]   m_grnt;
  logic         m_rdy;
  logic [31:0]  s_addr, s_wr_data;
  logic         s_as, s_rw, s_rdy;

  int checks = 0;
  int fails  = 0;

  bit mdl_owned;
  int mdl_own, mdl_last, mdl_hold;

  bus_arb #(.NUM_M(4), .MAX_HOLD(MH)) dut (
    .clk       (clk),
    .rst       (rst),
    .m_req     (m_req),
    .m_addr    (m_addr),
    .m_as      (m_as),
    .m_rw      (m_rw),
    .m_wr_data (m_wr_data),
    .m_grnt    (m_grnt),
    .m_rdy     (m_rdy),
    .s_addr    (s_addr),
    .s_as      (s_as),
    .s_rw      (s_rw),
    .s_wr_data (s_wr_data),
    .s_rdy     (s_rdy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int pick(input logic [3:0] req, input int from, input int excl);
    for (int k = 1; k <= 4; k++) begin
      int c;
      c = (from + k) % 4;
      if (req[c] && c != excl) return c;
    end
    return -1;
  endfunction

  task automatic model_step();
    int p;
    if (rst) begin
      mdl_owned = 0; mdl_own = 0; mdl_last = 3; mdl_hold = 0;
    end else if (!mdl_owned) begin
      p = pick(m_req, mdl_last, -1);
      if (p >= 0) begin
        mdl_owned = 1; mdl_own = p; mdl_last = p; mdl_hold = 0;
      end
    end else if (!m_req[mdl_own]) begin
      p = pick(m_req, mdl_last, -1);
      if (p >= 0) begin
        mdl_own = p; mdl_last = p; mdl_hold = 0;
      end else begin
        mdl_owned = 0; mdl_hold = 0;
      end
    end else begin
      p = pick(m_req, mdl_last, mdl_own);
      if (p >= 0 && mdl_hold == MH - 1 && !m_as[mdl_own]) begin
        mdl_own = p; mdl_last = p; mdl_hold = 0;
      end else if (mdl_hold < MH - 1) begin
        mdl_hold++;
      end
    end
  endtask

  task automatic compare_all();
    logic [3:0] eg;
    eg = mdl_owned ? (4'b0001 << mdl_own) : 4'b0000;
    check("grnt", {28'b0, m_grnt}, {28'b0, eg});
    check("s_addr", s_addr, mdl_owned ? m_addr[mdl_own*32 +: 32] : 32'h0);
    check("s_as", {31'b0, s_as}, {31'b0, mdl_owned ? m_as[mdl_own] : 1'b0});
    check("s_rw", {31'b0, s_rw}, {31'b0, mdl_owned ? m_rw[mdl_own] : 1'b0});
    check("s_wr_data", s_wr_data, mdl_owned ? m_wr_data[mdl_own*32 +: 32] : 32'h0);
    check("m_rdy", {31'b0, m_rdy}, {31'b0, s_rdy});
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic rand_bus();
    for (int i = 0; i < 4; i++) begin
      m_addr[i*32 +: 32]    = $urandom;
      m_wr_data[i*32 +: 32] = $urandom;
    end
    m_rw  = 4'($urandom);
    s_rdy = 1'($urandom);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    mdl_owned = 0; mdl_own = 0; mdl_last = 3; mdl_hold = 0;
    rst = 1'b1; m_req = '0; m_as = '0; m_rw = '0; s_rdy = 1'b0;
    m_addr = '0; m_wr_data = '0;
    #2;

    // Reset state
    tick();
    tick();
    check("reset_grnt", {28'b0, m_grnt}, 32'h0);
    check("reset_s_addr", s_addr, 32'h0);
    rst = 1'b0;
    rand_bus();
    tick(); tick(); tick();

    // Single request: grant one cycle later, bus follows master 1
    m_req = 4'b0010; m_as = 4'b0010;
    tick();
    check("first_grant", {28'b0, m_grnt}, 32'h2);
    check("first_addr", s_addr, m_addr[63:32]);
    check("first_as", {31'b0, s_as}, 32'h1);

    // Sole owner releases, then re-requests
    m_req = 4'b0000; m_as = 4'b0000;
    tick();
    check("release_idle", {28'b0, m_grnt}, 32'h0);
    m_req = 4'b0010;
    tick();
    check("regrant", {28'b0, m_grnt}, 32'h2);
    m_req = 4'b0000;
    tick();

    // Round-robin rotation with all requesting
    do_reset();
    m_req = 4'b1111; m_as = 4'b0000;
    tick();
    check("rr_0", {28'b0, m_grnt}, 32'h1);
    for (int i = 0; i < 4; i++) begin
      tick();
      tick();
      m_req[i] = 1'b0;
      tick();
      check($sformatf("rr_%0d", i + 1), {28'b0, m_grnt}, 32'(4'b0001 << ((i + 1) % 4)));
      m_req = 4'b1111;
    end
    m_req = 4'b0000;
    tick();

    // Same-edge handover from owner 2 to master 0
    do_reset();
    rand_bus();
    m_req = 4'b0100;
    tick();
    check("ho_owner2", {28'b0, m_grnt}, 32'h4);
    m_req = 4'b0101;
    tick();
    m_req = 4'b0001;
    tick();
    check("ho_grant0", {28'b0, m_grnt}, 32'h1);
    check("ho_addr0", s_addr, m_addr[31:0]);

    // Hold-time limit with strobe low: preempt on the 4th owned edge
    do_reset();
    m_req = 4'b0001; m_as = 4'b1000;
    tick();
    m_req = 4'b1001;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("to_hold", {28'b0, m_grnt}, 32'h1);
    end
    tick();
    check("to_preempt", {28'b0, m_grnt}, 32'h8);
    check("to_as3", {31'b0, s_as}, 32'h1);

    // Hold-time limit with strobe high: no preemption until strobe drops
    do_reset();
    m_req = 4'b0001; m_as = 4'b0001;
    tick();
    m_req = 4'b1001;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("as_hold", {28'b0, m_grnt}, 32'h1);
    end
    m_as = 4'b0000;
    tick();
    check("as_release", {28'b0, m_grnt}, 32'h8);

    // Reset in the middle of master 1's ownership
    do_reset();
    rand_bus();
    m_req = 4'b0010; m_as = 4'b0010;
    tick();
    tick();
    rst = 1'b1;
    tick();
    check("mid_rst_grnt", {28'b0, m_grnt}, 32'h0);
    check("mid_rst_as", {31'b0, s_as}, 32'h0);
    check("mid_rst_addr", s_addr, 32'h0);
    rst = 1'b0;
    m_req = 4'b0011;
    tick();
    check("post_rst_first", {28'b0, m_grnt}, 32'h1);

    // Random traffic against the model
    m_req = '0;
    for (int n = 0; n < 600; n++) begin
      rst = ($urandom_range(0, 79) == 0);
      if ($urandom_range(0, 2) == 0) m_req ^= 4'(1 << $urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) m_as = 4'($urandom);
      rand_bus();
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/bus_arb.md
Name: bus_arb

Overview:
- Master-side counterpart of the slave chip-select decoder on the shared system bus.
- Arbitrates up to four bus masters with round-robin priority and holds the grant for the owner's transaction.
- Muxes the owner's address and control onto the shared bus that feeds the slave decoder.
- Adds a hold-time limit so that no master can starve the others.

Parameters:
- NUM_M, 4, number of masters (fixed at 4; owner index is 2 bits).
- MAX_HOLD, 16, cycles an owner may keep the bus while others wait; 0 disables the limit.

Ports:
- clk  in  1  system clock. One clock domain; all state changes on rising edge.
- rst  in  1  reset. Synchronous, active-high.
- m_req  in  4  request per master, bit i = master i.
- m_addr  in  4*32  packed `WordAddrBus per master; master i occupies bits [32i+31:32i].
- m_as  in  4  address strobe per master.
- m_rw  in  4  per master: 1 = read, 0 = write.
- m_wr_data  in  4*32  packed write data per master.
- m_grnt  out  4  one-hot grant, registered.
- m_rdy  out  1  s_rdy broadcast to all masters; a master qualifies it with its own grant.
- s_addr  out  32  shared bus address, to the slave decoder and the slaves.
- s_as  out  1  shared address strobe.
- s_rw  out  1  shared read/write.
- s_wr_data  out  32  shared write data.
- s_rdy  in  1  ready from the selected slave.

Behaviour:
- State: IDLE/OWNED (1 bit), owner (2 bits), last (2 bits), hold_cnt (log2(MAX_HOLD)+1 bits), m_grnt register.
- Reset, applied on the clock edge with rst=1:
  - state=IDLE, m_grnt=4'b0000, owner=0, last=3, hold_cnt=0.
  - With last=3, master 0 has first priority after reset.
  - Outputs after reset: s_addr=0, s_as=`NO, s_rw=0, s_wr_data=0.
- Round-robin pick: the first i with m_req[i]=1, searched in order (last+1), (last+2), (last+3), (last+4) mod 4.
- IDLE:
  - If any m_req is set: m_grnt = onehot(pick), owner = last = pick, hold_cnt=0, go to OWNED.
  - Grant appears exactly 1 cycle after req is first sampled.
- OWNED, evaluated in priority order:
  1. m_req[owner]=0 (release): if any other req, grant moves to the next pick on the same edge (no dead cycle), hold_cnt=0. Otherwise m_grnt=0 and go to IDLE.
  2. Timeout: MAX_HOLD!=0, hold_cnt==MAX_HOLD-1, another master requesting, and m_as[owner]=0. Grant is forcibly moved to the pick with the owner excluded, and hold_cnt=0.
     - A timeout never preempts while m_as[owner]=1. The grant stays until the strobe drops.
  3. Otherwise keep the grant. hold_cnt increments and saturates at MAX_HOLD-1.
- Shared bus mux, combinational from the registered owner and grant:
  - When m_grnt!=0, s_addr/s_rw/s_wr_data take the owner's fields and s_as = m_as[owner].
  - When m_grnt==0, all shared outputs are 0 and s_as=`NO.
- m_rdy = s_rdy, unregistered.
- Ignored inputs: requests from masters that are not granted never affect the s_* outputs; m_as from a master that is not the owner is ignored.
- Simultaneous events: requests arriving on the release edge take part in that edge's pick.
- Reset mid-operation: the grant drops on that edge, s_as drops at once, and any in-flight slave transaction is abandoned. Slaves are reset by the same rst.
- Masters must hold m_req until their transaction completes. The arbiter does not track completion beyond m_as.

Decomposition:
- defines.v gets:
  - `YES/`NO, `WordAddrBus (shared with the decoder).
  - New: `MASTER_0..`MASTER_3 index constants.
  - New: `BUS_ARB_IDLE/`BUS_ARB_OWNED state encodings.
  - New: `MAX_HOLD_DEFAULT.
- One sub-module, rr_pick: combinational round-robin priority picker.
  - Inputs: req[3:0], last[1:0], excl_en, excl_idx.
  - Outputs: valid, idx[1:0].
  - Reused for both the release path and the timeout path.

Test Plan:
- Reset then m_req=0010 at cycle 5: m_grnt=0010 at cycle 6; s_addr = m_addr of master 1 and s_as = m_as[1] from cycle 6.
- After reset, m_req=1111 held and each owner drops its req 3 cycles after grant: grant order 0001, 0010, 0100, 1000, 0001, with no cycle where m_grnt=0.
- Owner 2 drops req while m_req[0] is set: m_grnt goes 0100 to 0001 on the same edge; s_addr switches to master 0's address the next cycle, with no gap.
- MAX_HOLD=4, master 0 holds req with m_as=0, master 3 requests: the grant moves to 1000 on the 4th owned edge. Repeat with m_as[0]=1: the grant stays 0001 until m_as[0] falls.
- rst=1 mid-ownership of master 1: on that edge m_grnt=0000, s_as=0, s_addr=0; after rst falls with m_req=0011, the grant goes to master 0 first.
- Sole owner drops req with no other requests: m_grnt=0000 and IDLE next cycle, s_* all 0. A re-request by the same master regains the grant 1 cycle later.
